rdyval2reqack_tph: RTL and testbench
====================================

Name: rdyval2reqack_tph

Overview:
Converts an input Ready–Valid handshake into an output two-phase Request–Acknowledge handshake. This is the transmit end matching the existing two-phase-to-Ready–Valid receiver.
- Each accepted word is launched by toggling req, with o_dat held stable until ack toggles to match.
- Optional CDC synchronizer on ack allows the link to cross a clock domain boundary.
- Optional one-word skid buffer lets the upstream keep streaming while a transfer is outstanding.

Parameters:
DWIDTH, 1, data path bit width.
INCLUDE_CDC, 1'b0, when 1 a 2-flop synchronizer is placed on ack; when 0 ack is used directly and must be in the clk domain.
BUF_DEPTH, 1, number of words held (1 = output register only; 2 = output register plus skid register); other values are illegal (elaboration $error).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active low
vld  input  1  input word valid
rdy  output  1  block can accept a word this cycle
i_dat  input  DWIDTH  input data
req  output  1  two-phase request; each toggle is one transfer
ack  input  1  two-phase acknowledge; toggles to equal req on completion
o_dat  output  DWIDTH  data for the outstanding request, stable while pending
busy  output  1  pending | skid_full, for idle detection / clock gating

Behaviour:
- Reset (asynchronous, rst_n low):
  - req=0, skid_full=0 and CDC sync flops=0.
  - Consequently rdy=1 and busy=0 once ack=0.
  - o_dat and the skid data register have no reset; their content is don't-care until the first req toggle.
- ack_i:
  - INCLUDE_CDC=0: ack_i = ack. This creates a combinational path ack->rdy/busy.
  - INCLUDE_CDC=1: ack_i = output of a 2-flop synchronizer, reset 0.
- pending = req ^ ack_i (combinational from flops); completion event = pending high and ack_i == req this cycle, i.e. pending falling.
- accept = vld & rdy. vld must hold and i_dat must stay stable until accept (upstream rule); the block does not check this.
- BUF_DEPTH=1:
  - rdy = ~pending.
  - On accept: o_dat <= i_dat and req <= ~req at the same clock edge.
  - Only one word is in flight.
- BUF_DEPTH=2:
  - rdy = ~skid_full.
  - accept while ~pending (and skid empty): launch directly; o_dat <= i_dat, req toggles.
  - accept while pending: skid <= i_dat, skid_full <= 1.
  - ~pending and skid_full: launch skid; o_dat <= skid, req toggles, skid_full <= 0. rdy is 0 this cycle, so no simultaneous accept.
  - Word order is always preserved. At most 2 words are held: 1 in flight and 1 in the skid register.
- Latency:
  - accept at edge N -> req toggled after edge N.
  - Without CDC: an ack toggle in cycle M makes rdy high in cycle M (BUF_DEPTH=1), and a skid launch happens at edge M.
  - With CDC: add 2 clk cycles of ack latency.
- Throughput, no CDC, ack returned 1 cycle after req: one word per 2 cycles with BUF_DEPTH=1. BUF_DEPTH=2 hides upstream stall but not the link round trip.
- o_dat and req never change while pending.
- A spurious ack toggle while not pending is a protocol violation. The resulting behaviour is undefined and is flagged by an SVA assertion (not synthesized).
- Reset mid-transfer: req returns to 0 and the skid content is discarded. The remote end must be reset together with this block.

Decomposition:
- Shared package hs_pkg:
  - constant CDC_STAGES=2, used by this block and the receiver;
  - function for the pending (xor) check.
- One sub-module, hs_bit_sync: a CDC_STAGES-deep flop synchronizer with async active-low reset. Instantiated here under INCLUDE_CDC, and reusable by the receiver.
- Skid logic stays inline under a generate on BUF_DEPTH.

Test Plan:
1. Reset, then single word. vld=1, i_dat=8'hA5, DWIDTH=8. Expected: req 0->1 after the accept edge; o_dat=A5; rdy=0, busy=1. Then ack 0->1 (no CDC). Expected: rdy=1 in the same cycle; busy=0.
2. Stream 4 words (01,02,03,04), BUF_DEPTH=1, remote acks 1 cycle after each req edge. Expected: req toggles 4 times with final req=0; o_dat sequence 01..04; each word stable until its ack; 8 cycles total.
3. BUF_DEPTH=2, ack held off 10 cycles, vld=1 with 11 then 22. Expected: 11 launched; 22 accepted into skid; rdy=0 afterwards. On ack: 22 launched at that edge and rdy=1.
4. INCLUDE_CDC=1, ack toggles. Expected: rdy rises exactly 2 clk edges later; no change to rdy/req if ack glitches and returns to its old value before the sampling edge.
5. Assert rst_n mid-transfer with req=1 and skid full. Expected: req=0, rdy=1 (ack=0), busy=0 immediately, asynchronous to clk; the next word launches with req 0->1.
6. Extra ack toggle while idle. Expected: the SVA assertion fires (negative test).

Source files
------------

// File: rtl/hs_pkg.sv
// Shared definitions for the two-phase req/ack handshake blocks
// (transmitter and receiver).
package hs_pkg;

  localparam int CDC_STAGES = 2;

  // A transfer is outstanding whenever the two phase bits disagree.
  function automatic logic hs_pending(input logic req_ph, input logic ack_ph);
    return req_ph ^ ack_ph;
  endfunction

endpackage

// File: rtl/hs_bit_sync.sv
// Multi-flop single-bit synchronizer for the handshake phase bits,
// asynchronously cleared to 0.
module hs_bit_sync
  import hs_pkg::*;
#(
  parameter int STAGES = CDC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rdyval2reqack_tph_chk.sv
// Protocol checker for the two-phase link: ack may only toggle
// to take the value of an outstanding req.
module rdyval2reqack_tph_chk (
  input logic clk,
  input logic rst_n,
  input logic req,
  input logic ack
);

  a_no_spurious_ack: assert property (
    @(posedge clk) disable iff (!rst_n) $changed(ack) |-> (ack == req)
  );

endmodule

// File: rtl/rdyval2reqack_tph.sv
// Ready/valid to two-phase req/ack transmitter with optional ack
// synchronizer and optional one-word skid register.
module rdyval2reqack_tph
  import hs_pkg::*;
#(
  parameter int DWIDTH      = 1,
  parameter bit INCLUDE_CDC = 1'b0,
  parameter int BUF_DEPTH   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld,
  output logic              rdy,
  input  logic [DWIDTH-1:0] i_dat,
  output logic              req,
  input  logic              ack,
  output logic [DWIDTH-1:0] o_dat,
  output logic              busy
);

  logic              w_ack_i;
  logic              w_pending;
  logic              w_launch;
  logic              w_skid_full;
  logic [DWIDTH-1:0] w_launch_dat;
  logic              r_req;
  logic [DWIDTH-1:0] r_dat;

  generate
    if (BUF_DEPTH != 1 && BUF_DEPTH != 2) begin : g_bad_depth
      $error("rdyval2reqack_tph: BUF_DEPTH must be 1 or 2");
    end
  endgenerate

  generate
    if (INCLUDE_CDC) begin : g_cdc
      hs_bit_sync #(.STAGES(CDC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (ack),
        .o_q   (w_ack_i)
      );
    end else begin : g_no_cdc
      assign w_ack_i = ack;
    end
  endgenerate

  assign w_pending = hs_pending(r_req, w_ack_i);

  generate
    if (BUF_DEPTH == 2) begin : g_skid
      logic              r_skid_full;
      logic [DWIDTH-1:0] r_skid;
      logic              w_accept;

      assign rdy          = ~r_skid_full;
      assign w_accept     = vld & ~r_skid_full;
      // A held skid word always goes out before any new input word
      assign w_launch     = ~w_pending & (r_skid_full | w_accept);
      assign w_launch_dat = r_skid_full ? r_skid : i_dat;
      assign w_skid_full  = r_skid_full;

      // Skid occupancy: filled by an accept during a pending transfer,
      // emptied when the skid word is launched
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_skid_full <= 1'b0;
        end else if (~w_pending & r_skid_full) begin
          r_skid_full <= 1'b0;
        end else if (w_accept & w_pending) begin
          r_skid_full <= 1'b1;
        end
      end

      // Skid data capture (no reset, qualified by r_skid_full)
      always_ff @(posedge clk) begin
        if (w_accept & w_pending) begin
          r_skid <= i_dat;
        end
      end
    end else begin : g_direct
      assign rdy          = ~w_pending;
      assign w_launch     = vld & ~w_pending;
      assign w_launch_dat = i_dat;
      assign w_skid_full  = 1'b0;
    end
  endgenerate

  // Request phase: one toggle per launched word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= 1'b0;
    end else if (w_launch) begin
      r_req <= ~r_req;
    end
  end

  // Output data register, only written when a new transfer starts
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_dat <= w_launch_dat;
    end
  end

  assign req   = r_req;
  assign o_dat = r_dat;
  assign busy  = w_pending | w_skid_full;

endmodule

// File: tb/tb_rdyval2reqack_tph.sv
// Scoreboard bench for rdyval2reqack_tph: three instances cover direct,
// skid-buffered and synchronized-ack configurations.
module tb_rdyval2reqack_tph;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic vld1, rdy1, req1, ack1, busy1;
  logic vld2, rdy2, req2, ack2, busy2;
  logic vld3, rdy3, req3, ack3, busy3;
  logic [7:0] di1, do1, di2, do2, di3, do3;

  rdyval2reqack_tph #(.DWIDTH(8), .INCLUDE_CDC(1'b0), .BUF_DEPTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .vld(vld1), .rdy(rdy1), .i_dat(di1),
    .req(req1), .ack(ack1), .o_dat(do1), .busy(busy1));
  rdyval2reqack_tph #(.DWIDTH(8), .INCLUDE_CDC(1'b0), .BUF_DEPTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .vld(vld2), .rdy(rdy2), .i_dat(di2),
    .req(req2), .ack(ack2), .o_dat(do2), .busy(busy2));
  rdyval2reqack_tph #(.DWIDTH(8), .INCLUDE_CDC(1'b1), .BUF_DEPTH(1)) u3 (
    .clk(clk), .rst_n(rst_n), .vld(vld3), .rdy(rdy3), .i_dat(di3),
    .req(req3), .ack(ack3), .o_dat(do3), .busy(busy3));

  rdyval2reqack_tph_chk c1 (.clk(clk), .rst_n(rst_n), .req(req1), .ack(ack1));
  rdyval2reqack_tph_chk c2 (.clk(clk), .rst_n(rst_n), .req(req2), .ack(ack2));
  rdyval2reqack_tph_chk c3 (.clk(clk), .rst_n(rst_n), .req(req3), .ack(ack3));

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp1[$], exp2[$], exp3[$];
  logic prev1 = 1'b0, prev2 = 1'b0, prev3 = 1'b0;
  logic [7:0] hold1 = 8'h00, hold2 = 8'h00, hold3 = 8'h00;

  task automatic check_b(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_d(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: each req toggle presents a word; it must match the queue head
  always @(negedge clk) begin
    if (rst_n && req1 !== prev1) begin
      if (exp1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u1_launch: got word %h, expected none queued", do1);
      end else begin
        check_d("u1_o_dat", do1, exp1[0]);
        hold1 <= exp1[0];
        void'(exp1.pop_front());
      end
    end else if (rst_n && req1 !== ack1) begin
      check_d("u1_o_dat_stable", do1, hold1);
    end
    prev1 <= req1;
  end

  always @(negedge clk) begin
    if (rst_n && req2 !== prev2) begin
      if (exp2.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u2_launch: got word %h, expected none queued", do2);
      end else begin
        check_d("u2_o_dat", do2, exp2[0]);
        hold2 <= exp2[0];
        void'(exp2.pop_front());
      end
    end else if (rst_n && req2 !== ack2) begin
      check_d("u2_o_dat_stable", do2, hold2);
    end
    prev2 <= req2;
  end

  always @(negedge clk) begin
    if (rst_n && req3 !== prev3) begin
      if (exp3.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL u3_launch: got word %h, expected none queued", do3);
      end else begin
        check_d("u3_o_dat", do3, exp3[0]);
        hold3 <= exp3[0];
        void'(exp3.pop_front());
      end
    end else if (rst_n && req3 !== ack3) begin
      check_d("u3_o_dat_stable", do3, hold3);
    end
    prev3 <= req3;
  end

  initial begin
    rst_n = 1'b0;
    {vld1, vld2, vld3} = 3'b000;
    {ack1, ack2, ack3} = 3'b000;
    di1 = 8'h00; di2 = 8'h00; di3 = 8'h00;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset state
    check_b("rst_rdy1", rdy1, 1'b1); check_b("rst_busy1", busy1, 1'b0); check_b("rst_req1", req1, 1'b0);
    check_b("rst_rdy2", rdy2, 1'b1); check_b("rst_busy2", busy2, 1'b0); check_b("rst_req2", req2, 1'b0);
    check_b("rst_rdy3", rdy3, 1'b1); check_b("rst_busy3", busy3, 1'b0); check_b("rst_req3", req3, 1'b0);

    // Single word, direct ack
    vld1 = 1'b1; di1 = 8'hA5; exp1.push_back(8'hA5);
    step();
    vld1 = 1'b0;
    check_b("t1_req", req1, 1'b1); check_b("t1_rdy", rdy1, 1'b0); check_b("t1_busy", busy1, 1'b1);
    step();
    check_b("t1_rdy_wait", rdy1, 1'b0);
    ack1 = 1'b1;
    #1;
    check_b("t1_rdy_same_cycle", rdy1, 1'b1); check_b("t1_busy_done", busy1, 1'b0);

    // Skid buffer with ack held off
    vld2 = 1'b1; di2 = 8'h11; exp2.push_back(8'h11);
    step();
    check_b("t3_req_11", req2, 1'b1); check_b("t3_rdy_skid_free", rdy2, 1'b1);
    di2 = 8'h22; exp2.push_back(8'h22);
    step();
    vld2 = 1'b0;
    check_b("t3_rdy_skid_full", rdy2, 1'b0); check_b("t3_req_hold", req2, 1'b1); check_b("t3_busy", busy2, 1'b1);
    repeat (8) step();
    check_b("t3_rdy_stall", rdy2, 1'b0); check_b("t3_req_stall", req2, 1'b1);
    ack2 = 1'b1;
    #1;
    check_b("t3_rdy_before_launch", rdy2, 1'b0); check_b("t3_busy_skid", busy2, 1'b1);
    step();
    check_b("t3_req_22", req2, 1'b0); check_b("t3_rdy_after_launch", rdy2, 1'b1); check_b("t3_busy_22", busy2, 1'b1);
    ack2 = 1'b0;
    #1;
    check_b("t3_busy_done", busy2, 1'b0);

    // Synchronized ack: glitch is ignored, real toggle seen 2 edges later
    vld3 = 1'b1; di3 = 8'h3C; exp3.push_back(8'h3C);
    step();
    vld3 = 1'b0;
    check_b("t4_req", req3, 1'b1); check_b("t4_rdy", rdy3, 1'b0);
    ack3 = 1'b1;
    #2;
    ack3 = 1'b0;
    step();
    check_b("t4_glitch_rdy_a", rdy3, 1'b0);
    step();
    check_b("t4_glitch_rdy_b", rdy3, 1'b0);
    step();
    check_b("t4_glitch_req", req3, 1'b1);
    ack3 = 1'b1;
    step();
    check_b("t4_rdy_edge1", rdy3, 1'b0);
    step();
    check_b("t4_rdy_edge2", rdy3, 1'b1); check_b("t4_busy_done", busy3, 1'b0);

    // Reset mid-transfer with the skid full
    vld2 = 1'b1; di2 = 8'h33; exp2.push_back(8'h33);
    step();
    di2 = 8'h44; exp2.push_back(8'h44);
    step();
    vld2 = 1'b0;
    check_b("t5_req_pre", req2, 1'b1); check_b("t5_rdy_pre", rdy2, 1'b0); check_b("t5_busy_pre", busy2, 1'b1);
    #2;
    rst_n = 1'b0;
    {ack1, ack2, ack3} = 3'b000;
    exp2.delete();
    #1;
    check_b("t5_req_async", req2, 1'b0); check_b("t5_rdy_async", rdy2, 1'b1); check_b("t5_busy_async", busy2, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check_b("t5_rdy_release", rdy2, 1'b1);
    vld2 = 1'b1; di2 = 8'h55; exp2.push_back(8'h55);
    step();
    vld2 = 1'b0;
    check_b("t5_req_next", req2, 1'b1);
    ack2 = 1'b1;
    #1;
    check_b("t5_busy_next", busy2, 1'b0);

    // Four-word stream, ack one cycle after each req toggle
    vld1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp_req;
      exp_req = (i % 2 == 0);
      di1 = 8'(i + 1);
      exp1.push_back(8'(i + 1));
      step();
      check_b("t2_req_toggle", req1, exp_req);
      check_b("t2_rdy_pending", rdy1, 1'b0);
      step();
      check_b("t2_req_held", req1, exp_req);
      ack1 = req1;
      #1;
      check_b("t2_rdy_after_ack", rdy1, 1'b1);
      if (i == 3) vld1 = 1'b0;
    end
    check_b("t2_req_final", req1, 1'b0); check_b("t2_busy_final", busy1, 1'b0);

    step();
    step();
    check_d("drain1", 8'(exp1.size()), 8'h00);
    check_d("drain2", 8'(exp2.size()), 8'h00);
    check_d("drain3", 8'(exp3.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
